// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle: program-memory request/response channel,
// instruction valid/ready channel to the control FSM, redirect and run control.
//   master : the fetch unit (drives mem_req/mem_addr and the instr_* payload)
//   slave  : the environment (memory, control FSM, branch logic)
interface instr_fetch_if #(
  parameter int unsigned AW = 8
);
  logic          run;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [7:0]    mem_rdata;
  logic          instr_valid;
  logic [7:0]    instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          fetch_idle;

  modport master (
    input  run, mem_gnt, mem_rvalid, mem_rdata, instr_ready, redirect, redirect_pc,
    output mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_idle
  );

  modport slave (
    output run, mem_gnt, mem_rvalid, mem_rdata, instr_ready, redirect, redirect_pc,
    input  mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_idle
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit for the 8-bit CPU.
// Holds the PC, issues single-outstanding reads to program memory, buffers the
// returned bytes in a DEPTH-entry prefetch FIFO and presents the head entry to
// the control FSM with a valid/ready handshake. Supports redirect with flush
// and run/halt control.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - instr_fetch_if.master: run, mem_req/mem_addr/mem_gnt/mem_rvalid/
//          mem_rdata, instr_valid/instr/instr_pc/instr_ready,
//          redirect/redirect_pc, fetch_idle
module instr_fetch #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]    op_byte;
    logic [AW-1:0] pc;
  } entry_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] req_pc_q;
  logic          drop_q;
  logic          mem_req_q;
  logic          fetch_idle_q;
  logic          instr_valid_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  entry_t        fifo_q [DEPTH];

  logic          push_c;
  logic          pop_c;
  logic [CW-1:0] count_nxt_c;
  logic          room_c;

  // FIFO bookkeeping; redirect flushes and overrides any same-cycle push/pop
  always_comb begin
    push_c      = 1'b0;
    pop_c       = 1'b0;
    count_nxt_c = count_q;
    room_c      = 1'b0;
    if (!bus.redirect) begin
      push_c      = (state_q == S_WAIT) && bus.mem_rvalid && !drop_q;
      pop_c       = instr_valid_q && bus.instr_ready;
      count_nxt_c = count_q + CW'(push_c) - CW'(pop_c);
    end else begin
      count_nxt_c = '0;
    end
    // Only one request is ever outstanding, so a free slot after this
    // cycle's update guarantees the next response has somewhere to land.
    room_c = (count_nxt_c < DEPTH_C);
  end

  // Prefetch FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      instr_valid_q <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      count_q       <= count_nxt_c;
      instr_valid_q <= (count_nxt_c != '0);
      if (bus.redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push_c) begin
          fifo_q[wr_ptr_q] <= '{op_byte: bus.mem_rdata, pc: req_pc_q};
          wr_ptr_q         <= wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
    end
  end

  // Fetch control FSM with registered mem_req / fetch_idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      req_pc_q     <= '0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      fetch_idle_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.redirect) begin
            pc_q <= bus.redirect_pc;
          end
          if (bus.run && room_c) begin
            state_q      <= S_REQ;
            mem_req_q    <= 1'b1;
            fetch_idle_q <= 1'b0;
          end
        end

        S_REQ: begin
          if (bus.mem_gnt) begin
            // A redirect coincident with the grant lets the fetch complete
            // but marks its response for discard.
            req_pc_q     <= pc_q;
            drop_q       <= bus.redirect;
            pc_q         <= bus.redirect ? bus.redirect_pc : pc_q + AW'(1);
            state_q      <= S_WAIT;
            mem_req_q    <= 1'b0;
            fetch_idle_q <= 1'b0;
          end else if (bus.redirect) begin
            pc_q <= bus.redirect_pc;
            if (!bus.run) begin
              state_q      <= S_IDLE;
              mem_req_q    <= 1'b0;
              fetch_idle_q <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (bus.redirect) begin
            pc_q <= bus.redirect_pc;
          end
          if (bus.mem_rvalid) begin
            drop_q <= 1'b0;
            if (bus.run && room_c) begin
              state_q      <= S_REQ;
              mem_req_q    <= 1'b1;
              fetch_idle_q <= 1'b0;
            end else begin
              state_q      <= S_IDLE;
              mem_req_q    <= 1'b0;
              fetch_idle_q <= 1'b1;
            end
          end else if (bus.redirect) begin
            drop_q <= 1'b1;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          mem_req_q    <= 1'b0;
          fetch_idle_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = fifo_q[rd_ptr_q].op_byte;
  assign bus.instr_pc    = fifo_q[rd_ptr_q].pc;
  assign bus.fetch_idle  = fetch_idle_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: program memory returns mem[a] = a with
// configurable grant gating and response latency.
module tb_instr_fetch;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 2;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        gnt_en   = 1'b1;
  int unsigned rv_delay = 1;

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.AW(AW)) bus ();

  instr_fetch #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Memory: grant whenever enabled, respond rv_delay cycles after grant.
  assign bus.mem_gnt = bus.mem_req & gnt_en;

  logic        rv_busy = 1'b0;
  int unsigned rv_cnt  = 0;
  logic [7:0]  rv_data = 8'h00;

  always @(posedge clk) begin
    bus.mem_rvalid <= 1'b0;
    if (rv_busy) begin
      if (rv_cnt <= 1) begin
        bus.mem_rvalid <= 1'b1;
        bus.mem_rdata  <= rv_data;
        rv_busy        <= 1'b0;
      end else begin
        rv_cnt <= rv_cnt - 1;
      end
    end
    if (bus.mem_req && bus.mem_gnt) begin
      if (rv_delay <= 1) begin
        bus.mem_rvalid <= 1'b1;
        bus.mem_rdata  <= 8'(bus.mem_addr);
      end else begin
        rv_busy <= 1'b1;
        rv_cnt  <= rv_delay - 1;
        rv_data <= 8'(bus.mem_addr);
      end
    end
  end

  // Grant counter and log of consumed {instr, instr_pc}
  int unsigned gnt_cnt = 0;
  logic [15:0] popped [$];

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.mem_req && bus.mem_gnt) gnt_cnt++;
      if (bus.instr_valid && bus.instr_ready && !bus.redirect)
        popped.push_back({bus.instr, 8'(bus.instr_pc)});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_mem_req"},     32'(bus.mem_req),     32'd0);
    chk({pfx, "_mem_addr"},    32'(bus.mem_addr),    32'd0);
    chk({pfx, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({pfx, "_instr"},       32'(bus.instr),       32'd0);
    chk({pfx, "_instr_pc"},    32'(bus.instr_pc),    32'd0);
    chk({pfx, "_fetch_idle"},  32'(bus.fetch_idle),  32'd1);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.run         = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    gnt_en          = 1'b1;
    rv_delay        = 1;
    repeat (4) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int unsigned gbase;
    int unsigned pbase;
    int unsigned npop;

    // Reset values
    do_reset();
    chk_reset("rst");

    // 1: zero-wait streaming, latency and sequence
    bus.instr_ready = 1'b1;
    bus.run         = 1'b1;
    step();
    chk("t1_c1_mem_req",  32'(bus.mem_req),     32'd1);
    chk("t1_c1_mem_addr", 32'(bus.mem_addr),    32'h00);
    chk("t1_c1_valid",    32'(bus.instr_valid), 32'd0);
    step();
    chk("t1_c2_mem_req",  32'(bus.mem_req),     32'd0);
    chk("t1_c2_idle",     32'(bus.fetch_idle),  32'd0);
    chk("t1_c2_valid",    32'(bus.instr_valid), 32'd0);
    step();
    chk("t1_c3_valid",    32'(bus.instr_valid), 32'd1);
    chk("t1_c3_instr",    32'(bus.instr),       32'h00);
    chk("t1_c3_pc",       32'(bus.instr_pc),    32'h00);
    chk("t1_c3_mem_req",  32'(bus.mem_req),     32'd1);
    chk("t1_c3_mem_addr", 32'(bus.mem_addr),    32'h01);
    step();
    chk("t1_c4_valid",    32'(bus.instr_valid), 32'd0);
    step();
    chk("t1_c5_valid",    32'(bus.instr_valid), 32'd1);
    chk("t1_c5_instr",    32'(bus.instr),       32'h01);
    chk("t1_c5_pc",       32'(bus.instr_pc),    32'h01);
    step();
    step();
    chk("t1_c7_valid",    32'(bus.instr_valid), 32'd1);
    chk("t1_c7_instr",    32'(bus.instr),       32'h02);
    chk("t1_c7_pc",       32'(bus.instr_pc),    32'h02);

    // 2: back-pressure fills the FIFO, then resumes without loss
    do_reset();
    gbase   = gnt_cnt;
    pbase   = popped.size();
    bus.run = 1'b1;
    repeat (12) step();
    chk("t2_full_grants",  gnt_cnt - gbase,        32'(DEPTH));
    chk("t2_full_mem_req", 32'(bus.mem_req),       32'd0);
    chk("t2_full_idle",    32'(bus.fetch_idle),    32'd1);
    chk("t2_full_valid",   32'(bus.instr_valid),   32'd1);
    chk("t2_full_instr",   32'(bus.instr),         32'h00);
    bus.instr_ready = 1'b1;
    repeat (10) step();
    bus.run = 1'b0;
    repeat (10) step();
    npop = popped.size() - pbase;
    chk("t2_enough_pops",  32'(npop >= 5),         32'd1);
    chk("t2_pops_eq_gnts", npop,                   gnt_cnt - gbase);
    chk("t2_drained",      32'(bus.instr_valid),   32'd0);
    for (int i = 0; i < int'(npop); i++) begin
      chk($sformatf("t2_pop%0d_instr", i), 32'(popped[pbase + i][15:8]), 32'(i));
      chk($sformatf("t2_pop%0d_pc", i),    32'(popped[pbase + i][7:0]),  32'(i));
    end

    // 3: redirect during a slow response
    do_reset();
    bus.instr_ready = 1'b1;
    rv_delay        = 3;
    bus.run         = 1'b1;
    step();
    chk("t3_mem_req",      32'(bus.mem_req),     32'd1);
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    step();
    bus.redirect = 1'b0;
    chk("t3_flush_valid",  32'(bus.instr_valid), 32'd0);
    chk("t3_still_wait",   32'(bus.mem_req),     32'd0);
    chk("t3_not_idle",     32'(bus.fetch_idle),  32'd0);
    for (int i = 0; i < 20 && !bus.mem_req; i++) step();
    chk("t3_req_seen",     32'(bus.mem_req),     32'd1);
    chk("t3_req_addr",     32'(bus.mem_addr),    32'h40);
    for (int i = 0; i < 20 && !bus.instr_valid; i++) step();
    chk("t3_valid_seen",   32'(bus.instr_valid), 32'd1);
    chk("t3_instr",        32'(bus.instr),       32'h40);
    chk("t3_pc",           32'(bus.instr_pc),    32'h40);

    // 4: PC wrap from 0xFF to 0x00
    do_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFF;
    step();
    bus.redirect = 1'b0;
    chk("t4_pc_loaded",    32'(bus.mem_addr),    32'hFF);
    chk("t4_idle",         32'(bus.fetch_idle),  32'd1);
    bus.instr_ready = 1'b1;
    bus.run         = 1'b1;
    step();
    chk("t4_req_ff",       32'(bus.mem_req),     32'd1);
    chk("t4_addr_ff",      32'(bus.mem_addr),    32'hFF);
    step();
    chk("t4_pc_wrapped",   32'(bus.mem_addr),    32'h00);
    step();
    chk("t4_instr_ff",     32'(bus.instr),       32'hFF);
    chk("t4_pc_ff",        32'(bus.instr_pc),    32'hFF);
    chk("t4_next_req",     32'(bus.mem_req),     32'd1);
    chk("t4_next_addr",    32'(bus.mem_addr),    32'h00);

    // 5: grant withheld for four cycles
    do_reset();
    gnt_en          = 1'b0;
    bus.instr_ready = 1'b1;
    bus.run         = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_hold%0d_req", i),  32'(bus.mem_req),  32'd1);
      chk($sformatf("t5_hold%0d_addr", i), 32'(bus.mem_addr), 32'h00);
      step();
    end
    gnt_en = 1'b1;
    step();
    chk("t5_granted_req",  32'(bus.mem_req),     32'd0);
    chk("t5_pc_once",      32'(bus.mem_addr),    32'h01);
    step();
    chk("t5_instr",        32'(bus.instr),       32'h00);
    chk("t5_valid",        32'(bus.instr_valid), 32'd1);
    chk("t5_next_addr",    32'(bus.mem_addr),    32'h01);

    // 6: reset while waiting, stale response afterwards
    do_reset();
    bus.instr_ready = 1'b1;
    rv_delay        = 3;
    bus.run         = 1'b1;
    step();
    step();
    rst     = 1'b1;
    bus.run = 1'b0;
    #1;
    chk_reset("t6_rst");
    step();
    rst = 1'b0;
    step();
    step();
    chk("t6_stale_valid",  32'(bus.instr_valid), 32'd0);
    chk("t6_stale_idle",   32'(bus.fetch_idle),  32'd1);
    chk("t6_stale_req",    32'(bus.mem_req),     32'd0);
    rv_delay = 1;
    bus.run  = 1'b1;
    step();
    chk("t6_restart_req",  32'(bus.mem_req),     32'd1);
    chk("t6_restart_addr", 32'(bus.mem_addr),    32'h00);
    for (int i = 0; i < 20 && !bus.instr_valid; i++) step();
    chk("t6_valid",        32'(bus.instr_valid), 32'd1);
    chk("t6_instr",        32'(bus.instr),       32'h00);
    chk("t6_pc",           32'(bus.instr_pc),    32'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
